// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped instruction cache between fetch and memory controller
//
// Ports:
//   clk_in, rst_in      clock, asynchronous active-high reset
//   rdy_in              global ready; low freezes every register and array
//   fetch_req/addr      fetch request (level) and byte address
//   clear               RoB clear; drops the pending response
//   inst_ready/inst_out one-cycle instruction response
//   busy                high while a miss is being filled
//   mem_req/addr        fill request, held until mem_done
//   mem_done/data       fill completion and fill word

module icache_direct_mapped #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        clear,
  output logic        inst_ready,
  output logic [31:0] inst_out,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t               state;
  logic                 abort;
  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tag_arr  [LINES];
  logic [31:0]          data_arr [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  fill;
  logic                  unused_addr_bits;

  assign req_idx  = fetch_addr[INDEX_BITS+1:2];
  assign req_tag  = fetch_addr[31:INDEX_BITS+2];
  // The registered mem_addr doubles as the latched miss address.
  assign fill_idx = mem_addr[INDEX_BITS+1:2];
  assign fill_tag = mem_addr[31:INDEX_BITS+2];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign fill     = rdy_in && (state == S_MISS) && mem_done;
  assign unused_addr_bits = ^fetch_addr[1:0];

  // Tag/data storage carries no reset; the valid bits guard every read.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      abort      <= 1'b0;
      valid      <= '0;
      inst_ready <= 1'b0;
      inst_out   <= 32'h0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
    end else if (rdy_in) begin
      inst_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          // clear wins over a same-cycle request; the request is dropped.
          if (!clear && fetch_req) begin
            if (hit) begin
              inst_ready <= 1'b1;
              inst_out   <= data_arr[req_idx];
            end else begin
              state    <= S_MISS;
              mem_req  <= 1'b1;
              mem_addr <= {fetch_addr[31:2], 2'b00};
              busy     <= 1'b1;
            end
          end
        end
        S_MISS: begin
          if (mem_done) begin
            valid[fill_idx] <= 1'b1;
            mem_req         <= 1'b0;
            busy            <= 1'b0;
            state           <= S_IDLE;
            abort           <= 1'b0;
            // A clear on the completing cycle suppresses the response too.
            if (!abort && !clear) begin
              inst_ready <= 1'b1;
              inst_out   <= mem_data;
            end
          end else if (clear) begin
            abort <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache directly upstream of instruction fetch.
- Takes the fetch address and a request from fetch.
- Returns the 32-bit instruction with a one-cycle ready pulse. Fetch consumes these on its ready_in and inst_in inputs.
- Misses are filled from the memory controller over a request/done handshake. A RoB clear aborts any response still in flight.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines, one 32-bit word per line)
- TAG_BITS, 30-INDEX_BITS, tag width = addr[31:INDEX_BITS+2]

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global ready; when low, all state freezes
- fetch_req  input  1  fetch requests the word at fetch_addr (level, sampled each cycle)
- fetch_addr  input  32  byte address; bits [1:0] ignored
- clear  input  1  RoB clear; cancels any outstanding response
- inst_ready  output  1  one-cycle pulse; inst_out valid
- inst_out  output  32  instruction word
- busy  output  1  high while in MISS state
- mem_req  output  1  fill request to memory controller, held until mem_done
- mem_addr  output  32  word-aligned fill address ({fetch_addr[31:2],2'b00})
- mem_done  input  1  fill data valid this cycle
- mem_data  input  32  fill word

Behaviour:
- Reset (asynchronous, immediate):
  - All valid bits 0, state IDLE, abort flag 0.
  - inst_ready=0, inst_out=0, mem_req=0, mem_addr=0, busy=0.
  - Tag and data arrays need not reset.
- rdy_in low: no state, array or output register changes. mem_req holds its level. A mem_done arriving while rdy_in is low is not consumed.
- Index = fetch_addr[INDEX_BITS+1:2]. Tag = fetch_addr[31:INDEX_BITS+2].
- States: IDLE, MISS.
- IDLE, no clear, fetch_req=1, hit (valid and tag match): next cycle inst_ready=1 and inst_out=line data. Hit latency is 1 cycle. State stays IDLE, so back-to-back hits give one word per cycle.
- IDLE, no clear, fetch_req=1, miss:
  - Next cycle: state MISS, mem_req=1, mem_addr=word-aligned address, busy=1, inst_ready=0.
  - Requested address and index/tag are latched internally.
- MISS, mem_done=0: hold mem_req, mem_addr and latched address. fetch_req and fetch_addr are ignored.
- MISS, mem_done=1:
  - Write line (valid=1, latched tag, mem_data).
  - Next cycle: mem_req=0, busy=0, state IDLE.
  - If abort flag=0: inst_ready=1 and inst_out=mem_data. Miss latency is handshake + 1 cycle.
  - Abort flag clears.
- Clear in IDLE: inst_ready=0 next cycle, even if a hit was being looked up that cycle. clear takes priority over fetch_req in the same cycle; that request is dropped.
- Clear in MISS (including the mem_done cycle): set abort flag. The fill still completes and the line is written. No inst_ready is produced for that fill.
- Clear outside the MISS state leaves the abort flag at 0.
- inst_ready is never high for two cycles from a single request.
- Memory handshake: mem_req rises only from IDLE. It falls the cycle after the mem_done that completes it. Exactly one mem_done is expected per request.
- No invalidation port; the instruction stream is treated as read-only.
- Reset asserted mid-MISS: mem_req drops immediately and all lines are invalid. A late mem_done is ignored because the state is IDLE.

Test Plan:
- Reset, then fetch_req=1 with addr 0x0000_0000 → mem_req=1, mem_addr=0x0 next cycle. mem_done with data 0x0000_0013 → inst_ready=1, inst_out=0x0000_0013 the cycle after.
- Refetch 0x0 → hit: inst_ready=1, inst_out=0x0000_0013 one cycle after the request, and mem_req stays 0. Three consecutive hit addresses 0x0/0x4/0x8 (all pre-filled) → three consecutive ready pulses.
- Conflict: fill 0x0000_0104 (index 1, tag 1), then fetch 0x0000_0004 (index 1, tag 0) → miss, mem_addr=0x4. Then refetch 0x104 → miss again.
- Clear during MISS for addr 0x20: mem_done with 0xDEAD_BEEF → no inst_ready pulse. A subsequent fetch of 0x20 hits with inst_out=0xDEAD_BEEF.
- Hold rdy_in=0 for 5 cycles during MISS with mem_done pulsed → state, mem_req=1 and outputs unchanged. After rdy_in=1 and mem_done, fill completes normally.
- Assert rst_in mid-MISS → mem_req=0 immediately. A later fetch of a previously filled address misses.
